// File: rtl/inst_step_ctrl.sv
// inst_step_ctrl: tick divider, button debounce/edge detect, switch capture with per-button override, show-ahead instruction FIFO, pop counter
module inst_step_ctrl #(
  parameter int NUM_BTN = 2,
  parameter int BTN_ID_WIDTH = 1,
  parameter int INST_WIDTH = 8,
  parameter int DIV_WIDTH = 17,
  parameter int DEBOUNCE_DEPTH = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH = 8,
  parameter logic [NUM_BTN*INST_WIDTH-1:0] OVR_MASK = {8'hC0, 8'h00},
  parameter logic [NUM_BTN*INST_WIDTH-1:0] OVR_VALUE = {8'hC0, 8'h00}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_BTN-1:0]      i_btn,
  input  logic [INST_WIDTH-1:0]   i_sw,
  output logic [INST_WIDTH-1:0]   o_inst,
  output logic [BTN_ID_WIDTH-1:0] o_btn_id,
  output logic                    o_inst_valid,
  input  logic                    i_inst_ready,
  output logic [CNT_WIDTH-1:0]    o_inst_cnt,
  output logic                    o_drop,
  output logic                    o_fifo_full,
  output logic                    o_tick
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = INST_WIDTH + BTN_ID_WIDTH;
  logic [DIV_WIDTH-1:0] r_div;
  logic r_tick, r_tick_d, r_drop;
  logic [NUM_BTN-1:0][DEBOUNCE_DEPTH-1:0] r_sh;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_pop_cnt;
  logic [NUM_BTN-1:0] w_edge;
  logic [BTN_ID_WIDTH-1:0] w_win;
  logic [INST_WIDTH-1:0] w_mask, w_val, w_inst;
  logic w_push, w_multi, w_full, w_valid, w_pop, w_wr;
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_edge
    assign w_edge[g] = (&r_sh[g][DEBOUNCE_DEPTH-1:1]) & ~r_sh[g][0];
  end
  always_comb begin
    w_win = '0;
    for (int b = NUM_BTN - 1; b >= 0; b--) w_win = w_edge[b] ? BTN_ID_WIDTH'(b) : w_win;
  end
  assign w_mask = OVR_MASK[w_win*INST_WIDTH +: INST_WIDTH];
  assign w_val = OVR_VALUE[w_win*INST_WIDTH +: INST_WIDTH];
  assign w_inst = (i_sw & ~w_mask) | (w_val & w_mask);
  assign w_push = r_tick_d & (|w_edge);
  assign w_multi = |(w_edge & (w_edge - NUM_BTN'(1)));
  assign w_full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_valid = |r_cnt;
  assign w_pop = w_valid & i_inst_ready;
  assign w_wr = w_push & ~w_full;
  assign {o_inst, o_btn_id} = w_valid ? r_mem[r_rp] : '0;
  assign o_inst_valid = w_valid;
  assign o_fifo_full = w_full;
  assign o_inst_cnt = r_pop_cnt;
  assign o_drop = r_drop;
  assign o_tick = r_tick;
  always_ff @(posedge clk) if (w_wr) r_mem[r_wp] <= {w_inst, w_win};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_tick <= 1'b0;
      r_tick_d <= 1'b0;
      r_sh <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_pop_cnt <= '0;
      r_drop <= 1'b0;
    end else begin
      r_div <= r_div + DIV_WIDTH'(1);
      r_tick <= &r_div;
      r_tick_d <= r_tick;
      for (int b = 0; b < NUM_BTN; b++)
        if (r_tick) r_sh[b] <= {i_btn[b], r_sh[b][DEBOUNCE_DEPTH-1:1]};
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_pop) r_pop_cnt <= r_pop_cnt + CNT_WIDTH'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_drop <= r_drop | (w_push & (w_full | w_multi));
    end
  end
endmodule

// File: tb/tb_inst_step_ctrl.sv
// tb_inst_step_ctrl: directed self-checking bench for inst_step_ctrl
module tb_inst_step_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] i_btn = '0;
  logic [7:0] i_sw = '0;
  logic i_inst_ready = 1'b0;
  logic [7:0] o_inst;
  logic o_btn_id, o_inst_valid, o_drop, o_fifo_full, o_tick;
  logic [7:0] o_inst_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  inst_step_ctrl #(
    .NUM_BTN(2), .BTN_ID_WIDTH(1), .INST_WIDTH(8), .DIV_WIDTH(2),
    .DEBOUNCE_DEPTH(3), .FIFO_DEPTH(2), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_sw(i_sw),
    .o_inst(o_inst), .o_btn_id(o_btn_id), .o_inst_valid(o_inst_valid),
    .i_inst_ready(i_inst_ready), .o_inst_cnt(o_inst_cnt), .o_drop(o_drop),
    .o_fifo_full(o_fifo_full), .o_tick(o_tick)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = o_tick;
    end
    chk("tick_timeout", {31'd0, seen}, 32'd1);
  endtask
  task automatic press(input logic [7:0] sw);
    i_btn[0] = 1'b0;
    wait_tick();
    wait_tick();
    i_btn[0] = 1'b1;
    i_sw = sw;
    wait_tick();
    @(negedge clk);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", o_inst_valid, 0);
    chk("rst_cnt", o_inst_cnt, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_full", o_fifo_full, 0);
    chk("rst_tick", o_tick, 0);
    chk("rst_inst", {o_btn_id, o_inst}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("tick_early", o_tick, 0);
    @(negedge clk);
    chk("tick_first", o_tick, 1);
    // scenario 1: btn0 held, sw 35
    i_btn = 2'b01;
    i_sw = 8'h35;
    i_inst_ready = 1'b1;
    @(negedge clk);
    chk("tick_pulse", o_tick, 0);
    wait_tick();
    @(negedge clk);
    chk("s1_valid_tickd", o_inst_valid, 0);
    @(negedge clk);
    chk("s1_valid", o_inst_valid, 1);
    chk("s1_inst", o_inst, 8'h35);
    chk("s1_id", o_btn_id, 0);
    @(negedge clk);
    chk("s1_popped", o_inst_valid, 0);
    chk("s1_cnt", o_inst_cnt, 1);
    repeat (4) wait_tick();
    chk("s1_held_cnt", o_inst_cnt, 1);
    chk("s1_held_valid", o_inst_valid, 0);
    // scenario 2: btn1 with forced opcode bits
    i_btn = 2'b10;
    i_sw = 8'h15;
    i_inst_ready = 1'b0;
    wait_tick();
    @(negedge clk);
    @(negedge clk);
    chk("s2_valid", o_inst_valid, 1);
    chk("s2_inst", o_inst, 8'hD5);
    chk("s2_id", o_btn_id, 1);
    chk("s2_drop", o_drop, 0);
    i_inst_ready = 1'b1;
    @(negedge clk);
    chk("s2_cnt", o_inst_cnt, 2);
    // scenario 3: single-tick glitch on btn0
    wait_tick();
    i_btn = 2'b00;
    wait_tick();
    wait_tick();
    i_btn = 2'b01;
    wait_tick();
    i_btn = 2'b00;
    wait_tick();
    wait_tick();
    chk("s3_valid", o_inst_valid, 0);
    chk("s3_cnt", o_inst_cnt, 2);
    // scenario 4: simultaneous edges
    i_btn = 2'b11;
    i_sw = 8'h01;
    i_inst_ready = 1'b0;
    wait_tick();
    @(negedge clk);
    @(negedge clk);
    chk("s4_valid", o_inst_valid, 1);
    chk("s4_inst", o_inst, 8'h01);
    chk("s4_id", o_btn_id, 0);
    chk("s4_drop", o_drop, 1);
    chk("s4_single", o_fifo_full, 0);
    i_inst_ready = 1'b1;
    @(negedge clk);
    chk("s4_cnt", o_inst_cnt, 3);
    chk("s4_empty", o_inst_valid, 0);
    repeat (20) wait_tick();
    chk("s4_drop_sticky", o_drop, 1);
    chk("s4_cnt_held", o_inst_cnt, 3);
    // scenario 5: overflow with ready low
    i_btn = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("s5_rst_drop", o_drop, 0);
    i_inst_ready = 1'b0;
    press(8'h11);
    chk("s5_p1_inst", o_inst, 8'h11);
    chk("s5_p1_full", o_fifo_full, 0);
    press(8'h22);
    chk("s5_p2_full", o_fifo_full, 1);
    chk("s5_p2_drop", o_drop, 0);
    press(8'h33);
    chk("s5_p3_drop", o_drop, 1);
    chk("s5_p3_head", o_inst, 8'h11);
    i_inst_ready = 1'b1;
    @(negedge clk);
    chk("s5_pop1_inst", o_inst, 8'h22);
    chk("s5_pop1_full", o_fifo_full, 0);
    chk("s5_pop1_cnt", o_inst_cnt, 1);
    @(negedge clk);
    chk("s5_pop2_valid", o_inst_valid, 0);
    chk("s5_pop2_cnt", o_inst_cnt, 2);
    chk("s5_empty_inst", {o_btn_id, o_inst}, 0);
    // scenario 6: reset with queued entries and btn0 mid-debounce
    i_inst_ready = 1'b0;
    press(8'h44);
    press(8'h55);
    chk("s6_full", o_fifo_full, 1);
    chk("s6_head", o_inst, 8'h44);
    i_btn[0] = 1'b0;
    wait_tick();
    wait_tick();
    i_btn[0] = 1'b1;
    i_sw = 8'h66;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("s6_rst_valid", o_inst_valid, 0);
    chk("s6_rst_cnt", o_inst_cnt, 0);
    chk("s6_rst_drop", o_drop, 0);
    chk("s6_rst_tick", o_tick, 0);
    chk("s6_rst_full", o_fifo_full, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s6_tick_early", o_tick, 0);
    @(negedge clk);
    chk("s6_tick_first", o_tick, 1);
    @(negedge clk);
    @(negedge clk);
    chk("s6_no_entry_1tick", o_inst_valid, 0);
    wait_tick();
    @(negedge clk);
    chk("s6_valid_tickd", o_inst_valid, 0);
    @(negedge clk);
    chk("s6_valid", o_inst_valid, 1);
    chk("s6_inst", o_inst, 8'h66);
    chk("s6_id", o_btn_id, 0);
    chk("s6_cnt", o_inst_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
